bootram_ctrl: RTL and testbench
===============================

// Module: bootram_ctrl
// PURPOSE
//   Bus front-end for the 8 KiB boot RAM, built from four 2Kx8 single-port BRAM byte lanes
//   (lane n = bits [8n+7:8n]). Serves the CPU native bus (mem_s_*) with correct 1-cycle BRAM
//   read latency and a write-lock. Adds a byte-stream programming port (UART loader) that
//   fills the RAM sequentially before the CPU runs.
// PARAMETERS
//   AW       11   word address width per lane (2K words)
//   PW       13   programming byte pointer width (= AW+2)
// PORTS
//   clk           in   1    system clock
//   resetn        in   1    async active-low reset
//   mem_s_valid   in   1    CPU request valid
//   mem_s_ready   out  1    CPU request done (1-cycle pulse)
//   mem_s_addr    in   32   byte address; only [AW+1:2] used, decode is external
//   mem_s_wdata   in   32   write data
//   mem_s_wstrb   in   4    byte strobes; 0 = read
//   mem_s_rdata   out  32   read data, valid while mem_s_ready=1
//   wr_lock       in   1    1 = CPU writes suppressed
//   wr_err        out  1    sticky: CPU write attempted while locked
//   prog_en       in   1    programming mode; rising edge clears pointer
//   prog_valid    in   1    programming byte valid
//   prog_ready    out  1    programming byte accepted this cycle
//   prog_data     in   8    programming byte
//   prog_count    out  PW   bytes written since prog_en rose
//   prog_full     out  1    pointer reached 2^PW
//   ram_ce        out  1    BRAM clock enable (all lanes)
//   ram_wre       out  4    per-lane write enable
//   ram_ad        out  AW   BRAM word address
//   ram_din       out  32   BRAM write data (lane n on [8n+7:8n])
//   ram_dout      in   32   BRAM read data (valid the cycle after ce with wre=0)
// BEHAVIOUR
//   Reset: FSM=IDLE; mem_s_ready=0, mem_s_rdata=0, wr_err=0, prog_ready=0,
//     prog_count=0, prog_full=0; ram_ce=0, ram_wre=0 (asserted async, released sync).
//   ram_* outputs are combinational from FSM state + inputs; mem_s_ready/rdata are registered.
//   FSM states: IDLE, RD_WAIT, ACK.
//   IDLE, prog_en=1: CPU not served (mem_s_ready held 0). If prog_valid & !prog_full:
//     prog_ready=1, ram_ce=1, ram_ad=prog_count[PW-1:2], ram_wre=onehot(prog_count[1:0]),
//     ram_din={4{prog_data}}; prog_count+=1; prog_full set when count wraps to 0 (sticky until
//     next prog_en rise). Full -> prog_ready=0, bytes not consumed. One byte/cycle max.
//   IDLE, prog_en=0, mem_s_valid, wstrb=0 (cycle 0): ram_ce=1, ram_ad=addr[AW+1:2], -> RD_WAIT.
//   RD_WAIT (cycle 1): capture ram_dout into mem_s_rdata, set mem_s_ready -> ACK.
//   ACK (cycle 2): mem_s_ready=1 for exactly this cycle; ready cleared -> IDLE. Read latency=2.
//   IDLE, prog_en=0, mem_s_valid, wstrb!=0: ram_ce=1, ram_wre=wstrb if !wr_lock else 0,
//     ram_din=wdata; set mem_s_ready -> ACK (ready in cycle 1). Locked write: RAM untouched,
//     still acked, wr_err<=1 (cleared only by reset).
//   ACK never starts a new access; back-to-back requests re-sampled in IDLE next cycle.
//   prog_en rise (registered edge detect) clears prog_count/prog_full; takes effect the cycle
//     after the edge; a byte presented in that edge cycle is written at old pointer.
//   prog_en asserted mid CPU access: access completes (RD_WAIT/ACK), then prog owns IDLE.
//   prog_en deasserted with pending prog_valid: byte ignored, prog_ready=0.
//   ram_wre is never nonzero without ram_ce; ram_ce=0 in RD_WAIT and ACK.
//   Reset mid-transaction: access abandoned, no ready pulse, partial write may have landed.
// TESTING
//   Reset: hold resetn=0 -> all outputs 0; release -> FSM IDLE, mem_s_ready stays 0.
//   prog_en=1, stream 8 bytes 0x11..0x88 -> lanes written word0=0x44332211,
//     word1=0x88776655, prog_count=8; CPU read addr 0x4 -> rdata 0x88776655, ready in cycle 2.
//   CPU write 0xDEADBEEF wstrb=4'b0101 to addr 0x8, then read -> 0x00AD00EF, ready in cycle 1.
//   wr_lock=1, write 0xFFFFFFFF to addr 0x0 -> ready in cycle 1, ram_wre=0, wr_err=1,
//     readback unchanged 0x44332211.
//   Stream 8192 bytes -> prog_full=1, prog_count=0, 8193rd byte prog_ready=0; re-raise
//     prog_en -> prog_full=0.
//   mem_s_valid held during prog_en=1 -> no ready; drop prog_en -> request served normally.

Source files
------------

// File: rtl/bootram_ctrl.sv
// Boot RAM bus front-end: CPU native-bus access to four 2Kx8 BRAM byte lanes plus a
// sequential byte-stream programming port used by the loader before the CPU runs.
module bootram_ctrl #(
    parameter int AW = 11,
    parameter int PW = 13
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          mem_s_valid,
    output logic          mem_s_ready,
    input  logic [31:0]   mem_s_addr,
    input  logic [31:0]   mem_s_wdata,
    input  logic [3:0]    mem_s_wstrb,
    output logic [31:0]   mem_s_rdata,
    input  logic          wr_lock,
    output logic          wr_err,
    input  logic          prog_en,
    input  logic          prog_valid,
    output logic          prog_ready,
    input  logic [7:0]    prog_data,
    output logic [PW-1:0] prog_count,
    output logic          prog_full,
    output logic          ram_ce,
    output logic [3:0]    ram_wre,
    output logic [AW-1:0] ram_ad,
    output logic [31:0]   ram_din,
    input  logic [31:0]   ram_dout
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        ACK
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic          run_reg;
    logic          prog_en_d_reg;
    logic [PW-1:0] prog_count_reg;
    logic          prog_full_reg;
    logic          mem_s_ready_reg;
    logic [31:0]   mem_s_rdata_reg;
    logic          wr_err_reg;

    logic          cpu_wr;
    logic          prog_rise;
    logic [3:0]    prog_lane_sel;

    // Address bits outside the word index are decoded by the interconnect.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_s_addr[31:AW+2], mem_s_addr[1:0]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_sel
            assign prog_lane_sel[gi] = (prog_count_reg[1:0] == 2'(gi));
        end
    endgenerate

    assign prog_rise = prog_en & ~prog_en_d_reg;

    always_comb begin
        state_next = state_reg;
        ram_ce     = 1'b0;
        ram_wre    = 4'b0000;
        ram_ad     = mem_s_addr[AW+1:2];
        ram_din    = mem_s_wdata;
        prog_ready = 1'b0;
        cpu_wr     = 1'b0;
        case (state_reg)
            IDLE: begin
                // run_reg keeps the BRAM strobes quiet until the cycle after reset release.
                if (run_reg) begin
                    if (prog_en) begin
                        if (prog_valid && !prog_full_reg) begin
                            prog_ready = 1'b1;
                            ram_ce     = 1'b1;
                            ram_ad     = prog_count_reg[PW-1:2];
                            ram_wre    = prog_lane_sel;
                            ram_din    = {4{prog_data}};
                        end
                    end else if (mem_s_valid) begin
                        ram_ce = 1'b1;
                        if (mem_s_wstrb == 4'b0000) begin
                            state_next = RD_WAIT;
                        end else begin
                            ram_wre    = wr_lock ? 4'b0000 : mem_s_wstrb;
                            cpu_wr     = 1'b1;
                            state_next = ACK;
                        end
                    end
                end
            end
            RD_WAIT: state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= IDLE;
            run_reg         <= 1'b0;
            prog_en_d_reg   <= 1'b0;
            prog_count_reg  <= '0;
            prog_full_reg   <= 1'b0;
            mem_s_ready_reg <= 1'b0;
            mem_s_rdata_reg <= '0;
            wr_err_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            run_reg         <= 1'b1;
            prog_en_d_reg   <= prog_en;
            mem_s_ready_reg <= (state_reg == RD_WAIT) || cpu_wr;
            if (state_reg == RD_WAIT) begin
                mem_s_rdata_reg <= ram_dout;
            end
            if (cpu_wr && wr_lock) begin
                wr_err_reg <= 1'b1;
            end
            // A byte accepted in the prog_en edge cycle lands at the old pointer; the clear wins.
            if (prog_rise) begin
                prog_count_reg <= '0;
                prog_full_reg  <= 1'b0;
            end else if (prog_ready) begin
                prog_count_reg <= prog_count_reg + 1'b1;
                if (&prog_count_reg) begin
                    prog_full_reg <= 1'b1;
                end
            end
        end
    end

    assign mem_s_ready = mem_s_ready_reg;
    assign mem_s_rdata = mem_s_rdata_reg;
    assign wr_err      = wr_err_reg;
    assign prog_count  = prog_count_reg;
    assign prog_full   = prog_full_reg;

endmodule

// File: tb/tb_bootram_ctrl.sv
// Bench for bootram_ctrl: BRAM lane model, scoreboard queue of expected CPU responses
// checked by an independent monitor, directed scenarios then randomized traffic.
module tb_bootram_ctrl;
    localparam int AW = 11;
    localparam int PW = 13;
    localparam int WORDS = 2048;
    localparam int BYTES = 8192;

    logic          clk = 1'b0;
    logic          resetn;
    logic          mem_s_valid;
    logic          mem_s_ready;
    logic [31:0]   mem_s_addr;
    logic [31:0]   mem_s_wdata;
    logic [3:0]    mem_s_wstrb;
    logic [31:0]   mem_s_rdata;
    logic          wr_lock;
    logic          wr_err;
    logic          prog_en;
    logic          prog_valid;
    logic          prog_ready;
    logic [7:0]    prog_data;
    logic [PW-1:0] prog_count;
    logic          prog_full;
    logic          ram_ce;
    logic [3:0]    ram_wre;
    logic [AW-1:0] ram_ad;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout;

    always #5 clk = ~clk;

    bootram_ctrl #(.AW(AW), .PW(PW)) dut (
        .clk(clk), .resetn(resetn),
        .mem_s_valid(mem_s_valid), .mem_s_ready(mem_s_ready), .mem_s_addr(mem_s_addr),
        .mem_s_wdata(mem_s_wdata), .mem_s_wstrb(mem_s_wstrb), .mem_s_rdata(mem_s_rdata),
        .wr_lock(wr_lock), .wr_err(wr_err),
        .prog_en(prog_en), .prog_valid(prog_valid), .prog_ready(prog_ready),
        .prog_data(prog_data), .prog_count(prog_count), .prog_full(prog_full),
        .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_ad(ram_ad), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    // Physical BRAM lanes driven by the DUT.
    logic [31:0] bram [0:WORDS-1];
    always @(posedge clk) begin
        if (ram_ce) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_wre[i]) bram[ram_ad][8*i +: 8] <= ram_din[8*i +: 8];
            end
            ram_dout <= bram[ram_ad];
        end
    end

    // Reference model: intended memory contents and loader/error state.
    logic [31:0] ref_mem [0:WORDS-1];
    int          ref_count;
    bit          ref_full;
    bit          ref_err;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        int          lat;
        int          t0;
    } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (resetn === 1'b1 && mem_s_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check(e.is_rd ? "rd_latency" : "wr_latency", cyc - e.t0, e.lat);
                    if (e.is_rd) check("rd_data", mem_s_rdata, e.data);
                    $display("txn %s lat=%0d rdata=%08h", e.is_rd ? "RD" : "WR", cyc - e.t0, mem_s_rdata);
                end
            end
        end
    end

    task automatic wait_ready(output bit got);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk);
            #1;
            got = mem_s_ready;
        end
        check("ready_timeout", got, 1);
    endtask

    // Called at #1 after a posedge with the DUT idle.
    task automatic cpu_op(input bit wr, input logic [10:0] widx, input logic [31:0] wd,
                          input logic [3:0] strb, input bit lock);
        exp_t e;
        bit got;
        logic [3:0] exp_wre;
        mem_s_addr  = {19'($urandom), widx, 2'($urandom)};
        mem_s_wdata = wr ? wd : $urandom;
        mem_s_wstrb = wr ? strb : 4'b0000;
        wr_lock     = lock;
        mem_s_valid = 1'b1;
        e.is_rd = !wr;
        e.data  = ref_mem[widx];
        e.lat   = wr ? 1 : 2;
        e.t0    = cyc;
        exp_q.push_back(e);
        exp_wre = (wr && !lock) ? strb : 4'b0000;
        @(negedge clk);
        check("cpu_ram_ce", ram_ce, 1);
        check("cpu_ram_ad", ram_ad, widx);
        check("cpu_ram_wre", ram_wre, exp_wre);
        if (wr) begin
            if (lock) ref_err = 1'b1;
            else for (int i = 0; i < 4; i++) if (strb[i]) ref_mem[widx][8*i +: 8] = wd[8*i +: 8];
        end
        wait_ready(got);
        mem_s_valid = 1'b0;
        wr_lock     = 1'b0;
        @(posedge clk);
        #1;
        if (wr) check("wr_err", wr_err, ref_err);
    endtask

    task automatic prog_byte(input logic [7:0] d);
        logic [3:0] exp_wre;
        prog_valid = 1'b1;
        prog_data  = d;
        exp_wre    = 4'b0001 << (ref_count % 4);
        @(negedge clk);
        check("prog_ready", prog_ready, !ref_full);
        if (!ref_full) begin
            check("prog_wre", ram_wre, exp_wre);
            check("prog_ad", ram_ad, ref_count / 4);
        end
        @(posedge clk);
        #1;
        if (!ref_full) begin
            ref_mem[ref_count / 4][8*(ref_count % 4) +: 8] = d;
            ref_count = (ref_count + 1) % BYTES;
            if (ref_count == 0) ref_full = 1'b1;
        end
        prog_valid = 1'b0;
    endtask

    task automatic prog_start();
        prog_en = 1'b0;
        @(posedge clk); #1;
        prog_en = 1'b1;
        @(posedge clk); #1;
        ref_count = 0;
        ref_full  = 1'b0;
        check("prog_count_clr", prog_count, 0);
        check("prog_full_clr", prog_full, 0);
    endtask

    task automatic prog_end();
        prog_en = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        bit got;
        exp_t e;
        for (int i = 0; i < WORDS; i++) begin
            bram[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        ram_dout = 32'h0;
        ref_count = 0; ref_full = 1'b0; ref_err = 1'b0;
        resetn = 1'b0;
        mem_s_valid = 1'b0; mem_s_addr = '0; mem_s_wdata = '0; mem_s_wstrb = '0;
        wr_lock = 1'b0; prog_en = 1'b0; prog_valid = 1'b0; prog_data = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs",
              {mem_s_ready, mem_s_rdata, wr_err, prog_ready, prog_count, prog_full, ram_ce, ram_wre},
              '0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_ready", mem_s_ready, 0);
        end

        // Loader stream 0x11..0x88, then CPU read of word 1.
        prog_start();
        for (int i = 1; i <= 8; i++) prog_byte(8'(i * 17));
        check("prog_count_8", prog_count, 8);
        check("word0_model", ref_mem[0], 32'h44332211);
        check("word1_model", ref_mem[1], 32'h88776655);
        prog_end();
        prog_valid = 1'b1;
        @(negedge clk);
        check("prog_ready_when_off", prog_ready, 0);
        @(posedge clk); #1;
        prog_valid = 1'b0;
        cpu_op(1'b0, 11'd1, 32'h0, 4'b0000, 1'b0);

        // Byte-masked write then readback.
        cpu_op(1'b1, 11'd2, 32'hDEADBEEF, 4'b0101, 1'b0);
        check("masked_model", ref_mem[2], 32'h00AD00EF);
        cpu_op(1'b0, 11'd2, 32'h0, 4'b0000, 1'b0);

        // Locked write: acked, RAM untouched, sticky error.
        cpu_op(1'b1, 11'd0, 32'hFFFFFFFF, 4'b1111, 1'b1);
        check("wr_err_set", wr_err, 1);
        cpu_op(1'b0, 11'd0, 32'h0, 4'b0000, 1'b0);

        // Full 8 KiB stream, overflow byte refused, re-arm clears full.
        prog_start();
        for (int i = 0; i < BYTES; i++) prog_byte(8'($urandom));
        check("prog_full_set", prog_full, 1);
        check("prog_count_wrap", prog_count, 0);
        prog_byte(8'hA5);
        prog_end();
        cpu_op(1'b0, 11'd0, 32'h0, 4'b0000, 1'b0);
        for (int i = 0; i < 16; i++) cpu_op(1'b0, 11'($urandom), 32'h0, 4'b0000, 1'b0);
        prog_start();
        check("prog_full_rearm", prog_full, 0);

        // CPU request held while the loader owns the port.
        mem_s_addr  = {19'h0, 11'd5, 2'b00};
        mem_s_wstrb = 4'b0000;
        mem_s_valid = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        e.is_rd = 1'b1; e.data = ref_mem[5]; e.lat = 2; e.t0 = cyc;
        exp_q.push_back(e);
        prog_en = 1'b0;
        wait_ready(got);
        mem_s_valid = 1'b0;
        @(posedge clk); #1;

        // Randomized mix of reads, writes (some locked) and short loader bursts.
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4) begin
                cpu_op(1'b0, 11'($urandom_range(0, 31)), 32'h0, 4'b0000, 1'b0);
            end else if (r < 8) begin
                cpu_op(1'b1, 11'($urandom_range(0, 31)), $urandom,
                       4'($urandom_range(1, 15)), ($urandom_range(0, 3) == 0));
            end else begin
                int len;
                len = $urandom_range(1, 12);
                prog_start();
                for (int k = 0; k < len; k++) prog_byte(8'($urandom));
                check("prog_count_burst", prog_count, ref_count);
                prog_end();
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
